// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage with a data-memory handshake FSM, branch/jump redirect and the MEM/WB register.
// Define MEM_TIMEOUT_EN to give up on an access after 16 BUSY edges and pulse mem_err.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MenWrtoMe,
    input  logic        MentoRegtoMe,
    input  logic        RegWrtoMe,
    input  logic        BtoMe,
    input  logic        zerotoMe,
    input  logic        JtoMe,
    input  logic        jrtoMe,
    input  logic        jartoMe,
    input  logic [4:0]  rwtoMe,
    input  logic [31:0] ALUout,
    input  logic [31:0] busBtoMe,
    input  logic [31:0] busAtoMe,
    input  logic [31:0] pcNewtoMe,
    input  logic [31:0] BpctoMe,
    input  logic [31:0] JpctoMe,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        jumpSuccess,
    output logic        Jr_jump,
    output logic [31:0] pcTarget,
`ifdef MEM_TIMEOUT_EN
    output logic        mem_err,
`endif
    output logic        RegWrtoWb,
    output logic [4:0]  rwtoWb,
    output logic [31:0] wbData
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state;
    logic        done;
    logic        memop;
    logic        timeout;
    logic        bubble;
    logic [31:0] rdata_q;
`ifdef MEM_TIMEOUT_EN
    logic [3:0]  cnt;
    assign timeout = state == BUSY && !dm_ack && cnt == 4'hF;
    assign bubble  = mem_err;
`else
    assign timeout = 1'b0;
    assign bubble  = 1'b0;
`endif
    assign memop       = MenWrtoMe | MentoRegtoMe;
    assign mem_stall   = (state == IDLE && memop && !done) || state == BUSY;
    assign jumpSuccess = (BtoMe & zerotoMe) | JtoMe;
    assign Jr_jump     = jrtoMe;
    assign pcTarget    = jrtoMe ? busAtoMe : JtoMe ? JpctoMe : BpctoMe;

    // Handshake FSM: issue on a fresh memop, hold the request until ack (or timeout), then flag done for one edge
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            rdata_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt      <= '0;
            mem_err  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt     <= (state == BUSY && !dm_ack) ? cnt + 4'd1 : 4'd0;
            mem_err <= timeout;
`endif
            if (state == IDLE) begin
                if (memop && !done) begin
                    state    <= BUSY;
                    dm_req   <= 1'b1;
                    dm_we    <= MenWrtoMe;
                    dm_addr  <= {ALUout[31:2], 2'b00};
                    dm_wdata <= busBtoMe;
                end
            end else if (dm_ack) begin
                state   <= IDLE;
                dm_req  <= 1'b0;
                done    <= 1'b1;
                rdata_q <= dm_rdata;
            end else if (timeout) begin
                state  <= IDLE;
                dm_req <= 1'b0;
                done   <= 1'b1;
            end
        end
    end

    // MEM/WB register: advance when not stalled, otherwise insert a bubble and keep the data
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrtoWb <= 1'b0;
            rwtoWb    <= '0;
            wbData    <= '0;
        end else if (mem_stall || bubble) begin
            RegWrtoWb <= 1'b0;
        end else begin
            RegWrtoWb <= RegWrtoMe;
            rwtoWb    <= rwtoMe;
            wbData    <= jartoMe ? pcNewtoMe : MentoRegtoMe ? rdata_q : ALUout;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench for mem_access_unit with a word-addressed memory responder.
// Define MEM_TIMEOUT_EN to also exercise the timeout path.
module tb_mem_access_unit;
    logic clk = 1'b1;
    logic rst_n = 1'b0;
    logic MenWrtoMe, MentoRegtoMe, RegWrtoMe, BtoMe, zerotoMe, JtoMe, jrtoMe, jartoMe;
    logic [4:0]  rwtoMe;
    logic [31:0] ALUout, busBtoMe, busAtoMe, pcNewtoMe, BpctoMe, JpctoMe;
    logic        dm_req, dm_we, dm_ack, mem_stall, jumpSuccess, Jr_jump, RegWrtoWb;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, pcTarget, wbData;
    logic [4:0]  rwtoWb;
`ifdef MEM_TIMEOUT_EN
    logic        mem_err;
`endif

    typedef struct {
        logic wr, ld, rwen, b, z, j, jr, jal;
        logic [4:0] rw;
        logic [31:0] alu, busb, busa, pcn, bpc, jpc;
    } instr_t;
    typedef struct { logic [31:0] addr, wdata; logic we; } req_t;
    typedef struct { logic [4:0] rw; logic [31:0] data; } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    int   lat_q[$];
    logic [31:0] mem_env [logic [31:0]];
    logic [31:0] mem_ref [logic [31:0]];
    int checks = 0, errors = 0;
    int force_lat = -1;
    int req_count = 0;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .MenWrtoMe(MenWrtoMe), .MentoRegtoMe(MentoRegtoMe), .RegWrtoMe(RegWrtoMe),
        .BtoMe(BtoMe), .zerotoMe(zerotoMe), .JtoMe(JtoMe), .jrtoMe(jrtoMe), .jartoMe(jartoMe),
        .rwtoMe(rwtoMe), .ALUout(ALUout), .busBtoMe(busBtoMe), .busAtoMe(busAtoMe),
        .pcNewtoMe(pcNewtoMe), .BpctoMe(BpctoMe), .JpctoMe(JpctoMe),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .mem_stall(mem_stall),
        .jumpSuccess(jumpSuccess), .Jr_jump(Jr_jump), .pcTarget(pcTarget),
`ifdef MEM_TIMEOUT_EN
        .mem_err(mem_err),
`endif
        .RegWrtoWb(RegWrtoWb), .rwtoWb(rwtoWb), .wbData(wbData)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Apply one instruction at the EX/MEM outputs and record what it should produce
    task automatic drive(input instr_t t, input bit push_wb);
        logic [31:0] a, d, tgt;
        MenWrtoMe = t.wr; MentoRegtoMe = t.ld; RegWrtoMe = t.rwen; BtoMe = t.b; zerotoMe = t.z;
        JtoMe = t.j; jrtoMe = t.jr; jartoMe = t.jal; rwtoMe = t.rw; ALUout = t.alu;
        busBtoMe = t.busb; busAtoMe = t.busa; pcNewtoMe = t.pcn; BpctoMe = t.bpc; JpctoMe = t.jpc;
        a = t.alu & ~32'h3;
        if (t.wr || t.ld) req_q.push_back('{a, t.busb, t.wr});
        d = t.jal ? t.pcn : t.ld ? (mem_ref.exists(a) ? mem_ref[a] : init_word(a)) : t.alu;
        if (t.wr) mem_ref[a] = t.busb;
        if (t.rwen && push_wb) wb_q.push_back('{t.rw, d});
        #1;
        tgt = t.jr ? t.busa : t.j ? t.jpc : t.bpc;
        check("redirect", {jumpSuccess, Jr_jump, pcTarget}, {(t.b & t.z) | t.j, t.jr, tgt});
    endtask

    // Hold the instruction until the stage accepts it (an edge with mem_stall low)
    task automatic run(input instr_t t, output int stalls);
        logic st;
        int l;
        drive(t, 1'b1);
        stalls = 0;
        forever begin
            @(posedge clk);
            st = mem_stall;
            @(negedge clk);
            #1;
            if (!st) break;
            stalls++;
            if (stalls > 100) begin
                errors++;
                $display("FAIL stall_bound actual=%0d required<=100", stalls);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "stall bound expired");
            end
        end
        if (t.wr || t.ld) begin
            if (lat_q.size() == 0) check("latency_record", 0, 1);
            else begin
                l = lat_q.pop_front();
                check("stall_cycles", stalls, l + 2);
            end
        end else check("stall_cycles_nonmem", stalls, 0);
    endtask

    function automatic instr_t nop();
        instr_t t;
        t = '{default: '0};
        return t;
    endfunction

    // Memory responder: acks requests after a chosen latency, throws spurious acks while idle
    initial begin
        bit busy = 0;
        int wait_n = 0;
        req_t cur, e;
        dm_ack = 1'b0;
        dm_rdata = '0;
        forever begin
            @(posedge clk);
            dm_ack = 1'b0;
            if (dm_req && !busy) begin
                busy = 1;
                req_count++;
                cur = '{dm_addr, dm_wdata, dm_we};
                if (req_q.size() == 0) check("req_unexpected", {dm_we, dm_addr}, 0);
                else begin
                    e = req_q.pop_front();
                    check("req_addr", dm_addr, e.addr);
                    check("req_kind", {dm_we, e.we ? dm_wdata : 32'h0}, {e.we, e.we ? e.wdata : 32'h0});
                end
                wait_n = force_lat >= 0 ? force_lat : $urandom_range(0, 3);
                lat_q.push_back(wait_n);
            end
            if (busy) begin
                if (!dm_req) busy = 0;
                else begin
                    check("req_stable", {dm_we, dm_addr, dm_wdata}, {cur.we, cur.addr, cur.wdata});
                    if (wait_n == 0) begin
                        dm_ack = 1'b1;
                        if (cur.we) begin
                            mem_env[cur.addr] = cur.wdata;
                            dm_rdata = $urandom;
                        end else dm_rdata = mem_env.exists(cur.addr) ? mem_env[cur.addr] : init_word(cur.addr);
                        busy = 0;
                    end else wait_n--;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                dm_ack = 1'b1;
                dm_rdata = $urandom;
            end
        end
    end

    // Writeback monitor: every cycle with RegWrtoWb high consumes one expected writeback
    initial begin
        wb_t e;
        forever begin
            @(posedge clk);
            if (RegWrtoWb) begin
                if (wb_q.size() == 0) check("wb_unexpected", {rwtoWb, wbData}, 0);
                else begin
                    e = wb_q.pop_front();
                    check("wb", {rwtoWb, wbData}, {e.rw, e.data});
                end
            end
        end
    end

    initial begin
        instr_t t;
        int s, rc;
        drive(nop(), 1'b0);
        #2;
        check("reset_ctl", {dm_req, dm_we, RegWrtoWb, rwtoWb, mem_stall}, 0);
        check("reset_data", {dm_addr, dm_wdata}, 0);
        check("reset_wb", wbData, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        mem_env[32'h1004] = 32'hDEAD_BEEF;
        mem_ref[32'h1004] = 32'hDEAD_BEEF;
        // load with two-edge wait
        force_lat = 1;
        t = nop(); t.ld = 1; t.rwen = 1; t.rw = 5'd9; t.alu = 32'h0000_1007;
        run(t, s);
        check("load_stall", s, 3);
        check("load_addr", dm_addr, 32'h0000_1004);
        check("load_wb", {RegWrtoWb, rwtoWb, wbData}, {1'b1, 5'd9, 32'hDEAD_BEEF});
        // store acked on the next edge
        force_lat = 0;
        rc = req_count;
        t = nop(); t.wr = 1; t.alu = 32'h0000_1008; t.busb = 32'h1234_5678;
        run(t, s);
        check("store_wr", {dm_we, dm_wdata}, {1'b1, 32'h1234_5678});
        check("store_one_req", req_count - rc, 1);
        check("store_no_wb", RegWrtoWb, 0);
        force_lat = -1;
        // branch taken, then jr over j
        t = nop(); t.b = 1; t.z = 1; t.bpc = 32'h40;
        run(t, s);
        t = nop(); t.jr = 1; t.j = 1; t.busa = 32'h80; t.jpc = 32'h99;
        run(t, s);
        // jal
        rc = req_count;
        t = nop(); t.jal = 1; t.j = 1; t.rwen = 1; t.rw = 5'd31; t.pcn = 32'h24; t.jpc = 32'h100;
        run(t, s);
        check("jal_wb", {RegWrtoWb, rwtoWb, wbData}, {1'b1, 5'd31, 32'h24});
        check("jal_no_req", req_count - rc, 0);
        // reset two edges after issue
        force_lat = 50;
        t = nop(); t.ld = 1; t.rwen = 1; t.rw = 5'd3; t.alu = 32'h2000;
        drive(t, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {dm_req, RegWrtoWb}, 0);
        rc = req_count;
        drive(nop(), 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("rst_no_reissue", {dm_req, 32'(req_count - rc)}, 0);
        lat_q.delete();
        force_lat = -1;
`ifdef MEM_TIMEOUT_EN
        begin
            int n;
            bit got;
            force_lat = 1000;
            t = nop(); t.ld = 1; t.rwen = 1; t.rw = 5'd7; t.alu = 32'h3000;
            drive(t, 1'b0);
            n = 0;
            got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(posedge clk);
                if (mem_err) got = 1;
                else if (dm_req) n++;
            end
            check("timeout_seen", {31'd0, got}, 1);
            check("timeout_edge", n, 16);
            check("timeout_release", {mem_stall, dm_req}, 0);
            @(negedge clk);
            #1;
            drive(nop(), 1'b0);
            @(posedge clk);
            check("timeout_pulse", {mem_err, RegWrtoWb}, 0);
            @(negedge clk);
            #1;
            lat_q.delete();
            force_lat = -1;
        end
`endif
        // randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            t = nop();
            t.rw = 5'($urandom); t.alu = 32'h1000 + $urandom_range(0, 63);
            t.busa = $urandom; t.busb = $urandom; t.pcn = $urandom; t.bpc = $urandom; t.jpc = $urandom;
            t.z = 1'($urandom);
            case ($urandom_range(0, 5))
                0: t.rwen = 1'($urandom);
                1: begin t.ld = 1; t.rwen = 1; end
                2: t.wr = 1;
                3: t.b = 1;
                4: begin t.jal = 1; t.j = 1; t.rwen = 1; end
                default: begin t.jr = 1; t.j = 1'($urandom); end
            endcase
            run(t, s);
        end
        drive(nop(), 1'b0);
        repeat (3) @(negedge clk);
        check("wb_drained", wb_q.size(), 0);
        check("req_drained", req_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
